// File: rtl/uart_rx_oversampled.sv
// UART receiver with a programmable clocks-per-bit divider and mid-bit sampling.
// Completed words are held behind a valid/ready handshake with parity, framing and overrun status.
module uart_rx_oversampled #(
    parameter int DATA_BITS = 8,
    parameter int BAUD_DIV  = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int HALF = BAUD_DIV / 2;
    localparam int CW   = $clog2(BAUD_DIV);
    localparam int IW   = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx_s;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 perr, perr_n;
    logic                 ferr, ferr_n;
    logic                 done;
    logic                 half_tick, tick, par_x;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign half_tick = (cnt == CW'(HALF - 1));
    assign tick      = (cnt == CW'(BAUD_DIV - 1));
    assign par_x     = (^shreg) ^ rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        shreg_n = shreg;
        perr_n  = perr;
        ferr_n  = ferr;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (half_tick) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                    // a high sample at mid-start is a line glitch, not a frame
                    state_n = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    if (idx == IW'(DATA_BITS - 1)) begin
                        idx_n   = '0;
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    cnt_n   = '0;
                    perr_n  = (PARITY == 1) ? par_x : ~par_x;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    cnt_n = '0;
                    if (!rx_s) ferr_n = 1'b1;
                    if (idx == IW'(STOP_BITS - 1)) begin
                        done    = 1'b1;
                        // on a framing error wait for the line to go idle so a break is one word
                        state_n = ferr_n ? S_WAIT_IDLE : S_IDLE;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end
            end
            S_WAIT_IDLE: begin
                cnt_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            perr  <= perr_n;
            ferr  <= ferr_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    parity_err <= perr_n;
                    frame_err  <= ferr_n;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule
